turbo_frame_checker: RTL and testbench
======================================

# turbo_frame_checker

Receive-side counterpart of the turbo stream encoder. It accepts the rate-1/3 symbol stream (systematic, parity1, parity2), one symbol per accepted cycle, and rebuilds each 8-bit data frame from the systematic bits. It re-encodes those bits through both constituent RSC trellises, the second in interleaved order, and reports per-symbol parity mismatches. The block sits between the channel symbol buffer and the byte sink, and is the hard-decision integrity check ahead of any soft decoder.

## Interface
- No parameters. Frame length is fixed at 8 symbols; the interleaver is fixed.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  symbol present on in_sys/in_p1/in_p2
- in_ready  out  1  block accepts a symbol this cycle
- in_sys  in  1  systematic bit u_k
- in_p1  in  1  constituent-1 parity for symbol k
- in_p2  in  1  constituent-2 parity for interleaved step k
- out_valid  out  1  frame result held on outputs
- out_ready  in  1  sink takes the result
- out_data  out  8  rebuilt byte; bit k = in_sys of the k-th symbol of the frame
- err1_mask  out  8  bit k = parity1 mismatch at symbol k
- err2_mask  out  8  bit j = parity2 mismatch at interleaved step j
- frame_ok  out  1  both masks zero
- err_frames  out  16  only with TURBO_RX_ERRCNT_EN

## Operation
- RSC model, one per constituent, with state s0..s3:
  - feedback a = u^s2^s3
  - parity = a^s0^s3
  - update s0<=a, s1<=s0, s2<=s1, s3<=s2
- Both trellis states persist across frames. Only rst clears them.
- Interleaver: step j of constituent 2 uses frame bit pos[j], where pos = {0,4,1,5,2,6,3,7}.
- The FSM has three states: COLLECT, CHECK2 and OUTPUT.
- COLLECT:
  - in_ready=1.
  - Each accepted symbol k (k=0..7) does the following:
    - writes in_sys to buf[k] and in_p2 to p2buf[k];
    - steps trellis 1 with u=in_sys;
    - sets err1_mask[k] = (computed p1 != in_p1).
  - After accepting k=7, the FSM goes to CHECK2 with j=0.
- CHECK2:
  - in_ready=0.
  - Each cycle steps trellis 2 with u=buf[pos[j]] and sets err2_mask[j] = (computed p2 != p2buf[j]).
  - After j=7, the FSM goes to OUTPUT.
- OUTPUT:
  - out_valid=1; out_data, both masks and frame_ok are held stable.
  - On out_valid&&out_ready, the FSM returns to COLLECT and both masks clear for the next frame.
- The symbol counter k (3 bits) wraps 7->0. The step counter j wraps 7->0.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, out_data=0x00, err1_mask=0x00, err2_mask=0x00, frame_ok=0, err_frames=0.
  - FSM=COLLECT, k=j=0, both trellis states 0.
- Symbols are accepted on edges where in_valid&&in_ready, back-to-back at one symbol per cycle. in_valid gaps stall without loss.
- Latency: out_valid rises 8 edges after the edge that accepts symbol 7.
- Minimum frame period is 17 cycles: 8 COLLECT, 8 CHECK2, 1 OUTPUT.
- out_ready held low keeps the results stable indefinitely. in_ready stays 0 throughout.
- The handshake edge in OUTPUT returns in_ready=1 on the next cycle. No symbol is accepted in the handshake cycle.
- rst mid-frame (any state) has the following effects:
  - the partial frame is discarded with no output produced;
  - all outputs and trellis states return to their reset values;
  - the next accepted symbol is k=0.
- The output registers update only at state transitions. Outputs are never combinational from in_*.

## Configuration
- TURBO_RX_ERRCNT_EN defined:
  - adds err_frames, a 16-bit saturating counter;
  - increments on each out handshake with frame_ok=0;
  - holds at 0xFFFF;
  - cleared by rst.
- TURBO_RX_ERRCNT_EN undefined: the err_frames port and counter are absent. All other behaviour is identical.

## Test plan
- All-zero frame after reset: sys=0, p1=0, p2=0 for 8 symbols, out_ready=1 -> out_data=0x00, err1_mask=0x00, err2_mask=0x00, frame_ok=1, out_valid 8 edges after the last accept.
- Byte 0x01 after reset:
  - stimulus: sys = 1,0,0,0,0,0,0,0 with p1 = p2 = 1,1,0,1,1,1,1,0;
  - required response: out_data=0x01, both masks 0x00, frame_ok=1.
- Same 0x01 frame with p2 inverted at step 3 and p1 inverted at symbol 6 -> err2_mask=0x08, err1_mask=0x40, frame_ok=0; with TURBO_RX_ERRCNT_EN, err_frames=1 after the handshake.
- Backpressure: out_ready=0 for 20 cycles in OUTPUT -> outputs stable, in_ready=0, no symbols consumed; out_ready=1 -> in_ready=1 on the next cycle.
- Reset after 5 accepted symbols, then a full 0x01 frame -> result identical to the byte 0x01 scenario, with no spurious out_valid.
- Two consecutive frames 0x01 then 0x00 without reset:
  - the second frame's parity is checked against the carried-over trellis states;
  - feeding the parities from a reference model gives frame_ok=1; feeding all-zero parities gives nonzero masks.

Source files
------------

// File: rtl/turbo_frame_checker.sv
// Turbo receive-side frame checker: rebuilds 8-bit frames from systematic bits and
// re-encodes them through both RSC trellises. Optional TURBO_RX_ERRCNT_EN adds err_frames.
module turbo_frame_checker (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sys,
  input  logic        in_p1,
  input  logic        in_p2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic [7:0]  err1_mask,
  output logic [7:0]  err2_mask,
  output logic        frame_ok
`ifdef TURBO_RX_ERRCNT_EN
  ,
  output logic [15:0] err_frames
`endif
);

  typedef enum logic [1:0] {COLLECT, CHECK2, OUTPUT} state_t;

  // Returns {parity, next_state}; state bit i holds s_i.
  function automatic logic [4:0] rsc_step(input logic [3:0] s, input logic u);
    logic a;
    a = u ^ s[2] ^ s[3];
    return {a ^ s[0] ^ s[3], s[2:0], a};
  endfunction

  function automatic logic [2:0] il_pos(input logic [2:0] step);
    case (step)
      3'd0:    il_pos = 3'd0;
      3'd1:    il_pos = 3'd4;
      3'd2:    il_pos = 3'd1;
      3'd3:    il_pos = 3'd5;
      3'd4:    il_pos = 3'd2;
      3'd5:    il_pos = 3'd6;
      3'd6:    il_pos = 3'd3;
      default: il_pos = 3'd7;
    endcase
  endfunction

  state_t     state;
  logic [2:0] k;
  logic [2:0] j;
  logic [3:0] tr1;
  logic [3:0] tr2;
  logic [7:0] sys_buf;
  logic [7:0] p2_buf;
  logic [7:0] mask1;
  logic [7:0] mask2;

  logic [4:0] step1;
  logic [4:0] step2;
  logic       p1_err;
  logic       p2_err;
  logic [7:0] mask2_nxt;

  assign step1     = rsc_step(tr1, in_sys);
  assign step2     = rsc_step(tr2, sys_buf[il_pos(j)]);
  assign p1_err    = step1[4] ^ in_p1;
  assign p2_err    = step2[4] ^ p2_buf[j];
  assign mask2_nxt = mask2 | ({7'd0, p2_err} << j);

  // Symbol buffers carry no reset: every slot is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (state == COLLECT && in_valid) begin
      sys_buf[k] <= in_sys;
      p2_buf[k]  <= in_p2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COLLECT;
      k         <= 3'd0;
      j         <= 3'd0;
      tr1       <= 4'd0;
      tr2       <= 4'd0;
      mask1     <= 8'd0;
      mask2     <= 8'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= 8'd0;
      err1_mask <= 8'd0;
      err2_mask <= 8'd0;
      frame_ok  <= 1'b0;
`ifdef TURBO_RX_ERRCNT_EN
      err_frames <= 16'd0;
`endif
    end else begin
      case (state)
        COLLECT: begin
          if (in_valid) begin
            tr1      <= step1[3:0];
            mask1[k] <= p1_err;
            k        <= k + 3'd1;
            if (k == 3'd7) begin
              state    <= CHECK2;
              in_ready <= 1'b0;
              j        <= 3'd0;
            end
          end
        end
        CHECK2: begin
          tr2   <= step2[3:0];
          mask2 <= mask2_nxt;
          j     <= j + 3'd1;
          // Results are published in one shot, including the final step-7 compare.
          if (j == 3'd7) begin
            state     <= OUTPUT;
            out_valid <= 1'b1;
            out_data  <= sys_buf;
            err1_mask <= mask1;
            err2_mask <= mask2_nxt;
            frame_ok  <= (mask1 == 8'd0) && (mask2_nxt == 8'd0);
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            state     <= COLLECT;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            mask1     <= 8'd0;
            mask2     <= 8'd0;
            err1_mask <= 8'd0;
            err2_mask <= 8'd0;
`ifdef TURBO_RX_ERRCNT_EN
            if (!frame_ok && err_frames != 16'hFFFF)
              err_frames <= err_frames + 16'd1;
`endif
          end
        end
        default: begin
          state     <= COLLECT;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_turbo_frame_checker.sv
// Directed self-checking bench for turbo_frame_checker with hand-computed parity vectors.
module tb_turbo_frame_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sys;
  logic        in_p1;
  logic        in_p2;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [7:0]  err1_mask;
  logic [7:0]  err2_mask;
  logic        frame_ok;
`ifdef TURBO_RX_ERRCNT_EN
  logic [15:0] err_frames;
`endif

  int errors = 0;
  int checks = 0;
  int lat;

  always #5 clk = ~clk;

  turbo_frame_checker dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sys(in_sys), .in_p1(in_p1), .in_p2(in_p2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .err1_mask(err1_mask), .err2_mask(err2_mask),
    .frame_ok(frame_ok)
`ifdef TURBO_RX_ERRCNT_EN
    , .err_frames(err_frames)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bit i of each vector is symbol i; gap inserts an idle cycle after each symbol.
  task automatic send_frame(input logic [7:0] s, input logic [7:0] p1, input logic [7:0] p2,
                            input bit gap);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_sys   = s[i];
      in_p1    = p1[i];
      in_p2    = p2[i];
      tick();
      in_valid = 1'b0;
      if (gap && i != 7) tick();
    end
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_result(input string tag, input logic [7:0] d, input logic [7:0] m1,
                            input logic [7:0] m2, input logic ok);
    chk({tag, ".out_valid"}, {15'd0, out_valid}, 16'd1);
    chk({tag, ".out_data"},  {8'd0, out_data},   {8'd0, d});
    chk({tag, ".err1"},      {8'd0, err1_mask},  {8'd0, m1});
    chk({tag, ".err2"},      {8'd0, err2_mask},  {8'd0, m2});
    chk({tag, ".frame_ok"},  {15'd0, frame_ok},  {15'd0, ok});
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_sys = 1'b0; in_p1 = 1'b0; in_p2 = 1'b0; out_ready = 1'b1;
    do_reset();
    chk("rst.in_ready",  {15'd0, in_ready},  16'd1);
    chk("rst.out_valid", {15'd0, out_valid}, 16'd0);
    chk("rst.out_data",  {8'd0, out_data},   16'd0);
    chk("rst.err1",      {8'd0, err1_mask},  16'd0);
    chk("rst.err2",      {8'd0, err2_mask},  16'd0);
    chk("rst.frame_ok",  {15'd0, frame_ok},  16'd0);
`ifdef TURBO_RX_ERRCNT_EN
    chk("rst.err_frames", err_frames, 16'd0);
`endif

    // All-zero frame from zero state: zero parity throughout.
    send_frame(8'h00, 8'h00, 8'h00, 1'b0);
    chk("zero.in_ready_check2", {15'd0, in_ready}, 16'd0);
    wait_out(lat);
    chk("zero.latency", lat[15:0], 16'd8);
    chk_result("zero", 8'h00, 8'h00, 8'h00, 1'b1);
    tick();
    chk("zero.in_ready_after", {15'd0, in_ready}, 16'd1);

    // Byte 0x01 with reference parity 1,1,0,1,1,1,1,0 (bit-reversed 0x7B), gapped input.
    send_frame(8'h01, 8'h7B, 8'h7B, 1'b1);
    wait_out(lat);
    chk("b01.latency", lat[15:0], 16'd8);
    chk_result("b01", 8'h01, 8'h00, 8'h00, 1'b1);
    tick();

    // 0x00 from carried state (s0..s3=0,1,0,1): parity 0,0,1,0,0,1,1,0 = 0x64.
    send_frame(8'h00, 8'h64, 8'h64, 1'b0);
    wait_out(lat);
    chk("carry.latency", lat[15:0], 16'd8);
    chk_result("carry", 8'h00, 8'h00, 8'h00, 1'b1);
    tick();

    // 0x01 with p1 flipped at symbol 6 and p2 flipped at step 3, then held under backpressure.
    do_reset();
    out_ready = 1'b0;
    send_frame(8'h01, 8'h3B, 8'h73, 1'b0);
    wait_out(lat);
    chk("err.latency", lat[15:0], 16'd8);
    chk_result("err", 8'h01, 8'h40, 8'h08, 1'b0);
    in_valid = 1'b1; in_sys = 1'b1; in_p1 = 1'b1; in_p2 = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("bp.in_ready", {15'd0, in_ready}, 16'd0);
      chk_result("bp", 8'h01, 8'h40, 8'h08, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp.release_valid", {15'd0, out_valid}, 16'd0);
    chk("bp.release_ready", {15'd0, in_ready},  16'd1);
`ifdef TURBO_RX_ERRCNT_EN
    chk("err.err_frames", err_frames, 16'd1);
`endif

    // Nothing consumed while stalled: next 0x00 frame with zero parity sees carried state.
    send_frame(8'h00, 8'h00, 8'h00, 1'b0);
    wait_out(lat);
    chk("zp.latency", lat[15:0], 16'd8);
    chk_result("zp", 8'h00, 8'h64, 8'h64, 1'b0);
    tick();
`ifdef TURBO_RX_ERRCNT_EN
    chk("zp.err_frames", err_frames, 16'd2);
`endif

    // Reset after five accepted symbols discards the partial frame and the trellis state.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_sys = i[0]; in_p1 = 1'b1; in_p2 = i[1];
      tick();
    end
    in_valid = 1'b0;
    do_reset();
    chk("mid.out_valid", {15'd0, out_valid}, 16'd0);
    chk("mid.in_ready",  {15'd0, in_ready},  16'd1);
    chk("mid.err1",      {8'd0, err1_mask},  16'd0);
`ifdef TURBO_RX_ERRCNT_EN
    chk("mid.err_frames", err_frames, 16'd0);
`endif
    send_frame(8'h01, 8'h7B, 8'h7B, 1'b0);
    wait_out(lat);
    chk("mid.latency", lat[15:0], 16'd8);
    chk_result("mid", 8'h01, 8'h00, 8'h00, 1'b1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
